// File: rtl/sync_format_detector.sv
// sync_format_detector
//   Receive side of the VDG timing interface. Samples HSn/FSn in the pixel
//   clock domain and measures the line period and the lines per frame. Each
//   frame is classified as 312-line (FrameFormat=0) or 262-line
//   (FrameFormat=1), and a SEARCH/ACQUIRE/LOCKED/HOLD state machine tracks
//   whether the incoming format is stable.
//
// Ports
//   i_clk            pixel clock, rising edge
//   i_resetn         synchronous active-low reset
//   i_hsn            horizontal sync, active low (rise = end of sync)
//   i_fsn            field sync, active low (rise = frame boundary)
//   o_locked         1 = stable recognised format
//   o_frame_format   0 = 312-line, 1 = 262-line (meaningful while locked)
//   o_line_period    clk cycles in the last complete line
//   o_frame_lines    HSn rises counted in the last complete frame
//   o_line_num       HSn rises since the last FSn rise (saturating)
//   o_col_num        clk cycles since the last HSn rise (saturating)
//   o_sync_error     one-cycle pulse on timeout or line-counter overflow
module sync_format_detector #(
  parameter int unsigned COLS_NOM     = 459,
  parameter int unsigned COL_TOL      = 2,
  parameter int unsigned LINES_312    = 312,
  parameter int unsigned LINES_262    = 262,
  parameter int unsigned LINE_TOL     = 1,
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned TIMEOUT_COLS = 1000
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          i_hsn,
  input  logic          i_fsn,
  output logic          o_locked,
  output logic          o_frame_format,
  output logic [9:0]    o_line_period,
  output logic [9:0]    o_frame_lines,
  output logic [9:0]    o_line_num,
  output logic [9:0]    o_col_num,
  output logic          o_sync_error
);

  localparam int unsigned CW = 10;
  localparam int unsigned MW = 3;

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] C_COLS_NOM = CW'(COLS_NOM);
  localparam logic [CW-1:0] C_COL_TOL  = CW'(COL_TOL);
  localparam logic [CW-1:0] C_L312     = CW'(LINES_312);
  localparam logic [CW-1:0] C_L262     = CW'(LINES_262);
  localparam logic [CW-1:0] C_LINE_TOL = CW'(LINE_TOL);
  localparam logic [CW-1:0] C_TIMEOUT  = CW'(TIMEOUT_COLS);
  localparam logic [MW-1:0] C_LOCK     = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // Absolute difference without wrap-around.
  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Input capture and edge-detect history
  logic          r_hs_s1, r_hs_s2;
  logic          r_fs_s1, r_fs_s2;

  // Measurement datapath
  logic [CW-1:0] r_col_num;
  logic [CW-1:0] r_line_num;
  logic [CW-1:0] r_line_period;
  logic [CW-1:0] r_frame_lines;
  logic          r_bad_line;
  logic          r_sync_err;

  // Lock state machine
  state_t        r_state;
  logic [MW-1:0] r_match;
  logic          r_prev_fmt;
  logic          r_have_prev;
  logic          r_locked;
  logic          r_frame_format;

  state_t        w_state_nx;
  logic [MW-1:0] w_match_nx;
  logic          w_prev_fmt_nx;
  logic          w_have_prev_nx;
  logic          w_locked_nx;
  logic          w_frame_format_nx;

  logic          w_hs_rise;
  logic          w_fs_rise;
  logic [CW:0]   w_period_raw;
  logic [CW-1:0] w_period;
  logic [CW-1:0] w_col_next;
  logic [CW-1:0] w_line_cnt;
  logic [CW-1:0] w_line_next;
  logic          w_period_ok;
  logic          w_line_bad;
  logic          w_frame_bad;
  logic          w_is_312;
  logic          w_is_262;
  logic          w_fmt;
  logic          w_frame_valid;
  logic          w_timeout;
  logic          w_overflow;
  logic          w_sync_err;

  // Edge detect on the registered copies; history resets high so no edge follows reset.
  assign w_hs_rise = r_hs_s1 & ~r_hs_s2;
  assign w_fs_rise = r_fs_s1 & ~r_fs_s2;

  // Period of the line ending now, clamped instead of wrapping past 1023.
  assign w_period_raw = {1'b0, r_col_num} + (CW+1)'(1);
  assign w_period     = w_period_raw[CW] ? CNT_MAX : w_period_raw[CW-1:0];

  assign w_col_next = w_hs_rise ? '0
                    : ((r_col_num == CNT_MAX) ? CNT_MAX : r_col_num + CW'(1));

  // Line count including a coincident HSn rise; this is what a frame reports.
  assign w_line_cnt  = (w_hs_rise && (r_line_num != CNT_MAX)) ? r_line_num + CW'(1)
                                                              : r_line_num;
  assign w_line_next = w_fs_rise ? '0 : w_line_cnt;

  assign w_period_ok = abs_diff(w_period, C_COLS_NOM) <= C_COL_TOL;
  assign w_line_bad  = w_hs_rise & ~w_period_ok;
  assign w_frame_bad = r_bad_line | w_line_bad;

  // Frame classification at the FSn rise; 312 wins if ranges ever overlap.
  assign w_is_312      = abs_diff(w_line_cnt, C_L312) <= C_LINE_TOL;
  assign w_is_262      = abs_diff(w_line_cnt, C_L262) <= C_LINE_TOL;
  assign w_fmt         = w_is_262 & ~w_is_312;
  assign w_frame_valid = ~w_frame_bad & (w_is_312 | w_is_262);

  // Timeout fires only on the transition into TIMEOUT_COLS, so one pulse per line.
  assign w_timeout  = (w_col_next == C_TIMEOUT) && (r_col_num != C_TIMEOUT);
  // Overflow fires only on the transition into saturation.
  assign w_overflow = w_hs_rise & ~w_fs_rise & (r_line_num == CNT_MAX - CW'(1));
  assign w_sync_err = w_timeout | w_overflow;

  // Measurement datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_hs_s1       <= 1'b1;
      r_hs_s2       <= 1'b1;
      r_fs_s1       <= 1'b1;
      r_fs_s2       <= 1'b1;
      r_col_num     <= '0;
      r_line_num    <= '0;
      r_line_period <= '0;
      r_frame_lines <= '0;
      r_bad_line    <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_hs_s1    <= i_hsn;
      r_hs_s2    <= r_hs_s1;
      r_fs_s1    <= i_fsn;
      r_fs_s2    <= r_fs_s1;
      r_col_num  <= w_col_next;
      r_line_num <= w_line_next;
      if (w_hs_rise) begin
        r_line_period <= w_period;
      end
      if (w_fs_rise) begin
        r_frame_lines <= w_line_cnt;
      end
      // Sticky per-frame flag, restarted at every frame boundary.
      r_bad_line <= w_fs_rise ? 1'b0 : (r_bad_line | w_line_bad);
      r_sync_err <= w_sync_err;
    end
  end

  // Lock state register
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state        <= ST_SEARCH;
      r_match        <= '0;
      r_prev_fmt     <= 1'b0;
      r_have_prev    <= 1'b0;
      r_locked       <= 1'b0;
      r_frame_format <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_match        <= w_match_nx;
      r_prev_fmt     <= w_prev_fmt_nx;
      r_have_prev    <= w_have_prev_nx;
      r_locked       <= w_locked_nx;
      r_frame_format <= w_frame_format_nx;
    end
  end

  // Lock next-state and output logic; sync errors override frame events.
  always_comb begin
    w_state_nx        = r_state;
    w_match_nx        = r_match;
    w_prev_fmt_nx     = r_prev_fmt;
    w_have_prev_nx    = r_have_prev;
    w_locked_nx       = r_locked;
    w_frame_format_nx = r_frame_format;

    if (w_sync_err) begin
      w_state_nx     = ST_SEARCH;
      w_locked_nx    = 1'b0;
      w_match_nx     = '0;
      w_have_prev_nx = 1'b0;
    end else if (w_fs_rise) begin
      unique case (r_state)
        ST_SEARCH: begin
          w_state_nx     = ST_ACQUIRE;
          w_match_nx     = '0;
          w_have_prev_nx = 1'b0;
        end
        ST_ACQUIRE: begin
          if (w_frame_valid && (!r_have_prev || (w_fmt == r_prev_fmt))) begin
            w_match_nx = r_match + MW'(1);
          end else begin
            w_match_nx = {{(MW-1){1'b0}}, w_frame_valid};
          end
          w_prev_fmt_nx  = w_fmt;
          // An invalid frame leaves no format to match against.
          w_have_prev_nx = w_frame_valid;
          if (w_frame_valid && (w_match_nx == C_LOCK)) begin
            w_state_nx        = ST_LOCKED;
            w_locked_nx       = 1'b1;
            w_frame_format_nx = w_fmt;
          end
        end
        ST_LOCKED: begin
          if (!w_frame_valid || (w_fmt != r_frame_format)) begin
            w_state_nx = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_frame_valid && (w_fmt == r_frame_format)) begin
            w_state_nx = ST_LOCKED;
          end else begin
            w_state_nx  = ST_SEARCH;
            w_locked_nx = 1'b0;
          end
        end
        default: begin
          w_state_nx = ST_SEARCH;
        end
      endcase
    end
  end

  assign o_locked       = r_locked;
  assign o_frame_format = r_frame_format;
  assign o_line_period  = r_line_period;
  assign o_frame_lines  = r_frame_lines;
  assign o_line_num     = r_line_num;
  assign o_col_num      = r_col_num;
  assign o_sync_error   = r_sync_err;

endmodule
